// File: rtl/texture_mapper_legup_mac_pipelined.sv
// Elastic pipelined multiply-accumulate unit with per-operand signedness, frame-based
// accumulation and a shifted, saturating output register.
module texture_mapper_legup_mac_pipelined #(
    parameter int unsigned widtha     = 16,
    parameter int unsigned widthb     = 16,
    parameter int unsigned widthacc   = 48,
    parameter int unsigned widthp     = 32,
    parameter int unsigned pipeline   = 3,
    parameter bit          signed_a   = 1'b1,
    parameter bit          signed_b   = 1'b1,
    parameter bit          accumulate = 1'b0,
    parameter int unsigned out_shift  = 0
) (
    input  logic                clock,
    input  logic                aclr,
    input  logic                clken,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_first,
    input  logic                in_last,
    input  logic [widtha-1:0]   dataa,
    input  logic [widthb-1:0]   datab,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [widthp-1:0]   result,
    output logic                out_sat
);

    localparam int unsigned NIn    = pipeline >> 1;
    localparam int unsigned NPr    = pipeline - NIn;
    localparam bit          Signed = signed_a | signed_b;

    logic adv;
    logic out_valid_q, out_valid_d;
    logic [widthacc-1:0] acc_q, acc_d, acc_next;
    logic [widthp-1:0]   result_q, result_d;
    logic                sat_q, sat_d;

    // The whole pipe, tags included, moves as one; a held output stalls everything.
    assign adv      = clken && !aclr && (!out_valid_q || out_ready);
    assign in_ready = adv;

    // Operands as they enter the multiplier (after the input register stages, if any)
    logic [widtha-1:0] a_m;
    logic [widthb-1:0] b_m;
    logic              v_m, f_m, l_m;

    if (NIn > 0) begin : g_in
        logic [widtha-1:0] a_q [NIn];
        logic [widthb-1:0] b_q [NIn];
        logic              v_q [NIn];
        logic              f_q [NIn];
        logic              l_q [NIn];

        always_ff @(posedge clock) begin
            if (aclr) begin
                for (int i = 0; i < int'(NIn); i++) begin
                    a_q[i] <= '0;
                    b_q[i] <= '0;
                    v_q[i] <= 1'b0;
                    f_q[i] <= 1'b0;
                    l_q[i] <= 1'b0;
                end
            end else if (adv) begin
                a_q[0] <= dataa;
                b_q[0] <= datab;
                v_q[0] <= in_valid;
                f_q[0] <= in_first;
                l_q[0] <= in_last;
                for (int i = 1; i < int'(NIn); i++) begin
                    a_q[i] <= a_q[i-1];
                    b_q[i] <= b_q[i-1];
                    v_q[i] <= v_q[i-1];
                    f_q[i] <= f_q[i-1];
                    l_q[i] <= l_q[i-1];
                end
            end
        end

        assign a_m = a_q[NIn-1];
        assign b_m = b_q[NIn-1];
        assign v_m = v_q[NIn-1];
        assign f_m = f_q[NIn-1];
        assign l_m = l_q[NIn-1];
    end else begin : g_in_none
        assign a_m = dataa;
        assign b_m = datab;
        assign v_m = in_valid;
        assign f_m = in_first;
        assign l_m = in_last;
    end

    logic [widthacc-1:0] a_ext, b_ext, prod_m;

    always_comb begin
        a_ext  = {{(widthacc-widtha){signed_a & a_m[widtha-1]}}, a_m};
        b_ext  = {{(widthacc-widthb){signed_b & b_m[widthb-1]}}, b_m};
        prod_m = a_ext * b_ext;
    end

    logic [widthacc-1:0] p_q  [NPr];
    logic                pv_q [NPr];
    logic                pf_q [NPr];
    logic                pl_q [NPr];

    always_ff @(posedge clock) begin
        if (aclr) begin
            for (int i = 0; i < int'(NPr); i++) begin
                p_q[i]  <= '0;
                pv_q[i] <= 1'b0;
                pf_q[i] <= 1'b0;
                pl_q[i] <= 1'b0;
            end
        end else if (adv) begin
            p_q[0]  <= prod_m;
            pv_q[0] <= v_m;
            pf_q[0] <= f_m;
            pl_q[0] <= l_m;
            for (int i = 1; i < int'(NPr); i++) begin
                p_q[i]  <= p_q[i-1];
                pv_q[i] <= pv_q[i-1];
                pf_q[i] <= pf_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
        end
    end

    logic [widthacc-1:0] prod;
    logic                pv, pf, pl;

    assign prod = p_q[NPr-1];
    assign pv   = pv_q[NPr-1];
    assign pf   = pf_q[NPr-1];
    assign pl   = pl_q[NPr-1];

    always_comb begin
        if (accumulate && !pf) acc_next = acc_q + prod;
        else                   acc_next = prod;
    end

    // Shift and clip the candidate accumulator value into the output width.
    logic [widthacc-1:0] shifted;
    logic [widthp-1:0]   fmt;
    logic                fmt_sat;

    always_comb begin
        shifted = '0;
        fmt     = '0;
        fmt_sat = 1'b0;
        if (Signed) begin
            shifted = $signed(acc_next) >>> out_shift;
            if (shifted[widthacc-1:widthp-1] == '0 || shifted[widthacc-1:widthp-1] == '1) begin
                fmt = shifted[widthp-1:0];
            end else begin
                fmt_sat = 1'b1;
                fmt     = shifted[widthacc-1] ? {1'b1, {(widthp-1){1'b0}}}
                                              : {1'b0, {(widthp-1){1'b1}}};
            end
        end else begin
            shifted = acc_next >> out_shift;
            if (shifted[widthacc-1:widthp] == '0) begin
                fmt = shifted[widthp-1:0];
            end else begin
                fmt_sat = 1'b1;
                fmt     = '1;
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        sat_d       = sat_q;
        if (adv) begin
            out_valid_d = 1'b0;
            if (pv) begin
                acc_d = acc_next;
                // Only a completed frame (or any beat when not accumulating) reaches the output.
                if (!accumulate || pl) begin
                    out_valid_d = 1'b1;
                    result_d    = fmt;
                    sat_d       = fmt_sat;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (aclr) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sat_q       <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_texture_mapper_legup_mac_pipelined.sv
// Directed bench for the pipelined MAC: several parameterisations share one stimulus bus.
module tb_texture_mapper_legup_mac_pipelined;

    logic        clock = 1'b0;
    logic        aclr, clken, in_valid, in_first, in_last, out_ready;
    logic [15:0] dataa, datab;

    logic        rdy_u, ov_u, sat_u;
    logic [31:0] res_u;
    logic        rdy_s, ov_s, sat_s;
    logic [31:0] res_s;
    logic        rdy_a, ov_a, sat_a;
    logic [31:0] res_a;
    logic        rdy_t, ov_t, sat_t;
    logic [7:0]  res_t;
    logic        rdy_h, ov_h, sat_h;
    logic [7:0]  res_h;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    texture_mapper_legup_mac_pipelined #(
        .signed_a(1'b0), .signed_b(1'b0), .accumulate(1'b0)
    ) u_uns (
        .clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_ready(rdy_u),
        .in_first(in_first), .in_last(in_last), .dataa(dataa), .datab(datab),
        .out_valid(ov_u), .out_ready(out_ready), .result(res_u), .out_sat(sat_u)
    );

    texture_mapper_legup_mac_pipelined #(
        .signed_a(1'b1), .signed_b(1'b1), .accumulate(1'b0)
    ) u_sgn (
        .clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_ready(rdy_s),
        .in_first(in_first), .in_last(in_last), .dataa(dataa), .datab(datab),
        .out_valid(ov_s), .out_ready(out_ready), .result(res_s), .out_sat(sat_s)
    );

    texture_mapper_legup_mac_pipelined #(
        .signed_a(1'b1), .signed_b(1'b1), .accumulate(1'b1)
    ) u_acc (
        .clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_ready(rdy_a),
        .in_first(in_first), .in_last(in_last), .dataa(dataa), .datab(datab),
        .out_valid(ov_a), .out_ready(out_ready), .result(res_a), .out_sat(sat_a)
    );

    texture_mapper_legup_mac_pipelined #(
        .widthp(8), .signed_a(1'b1), .signed_b(1'b1), .out_shift(0)
    ) u_sat (
        .clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_ready(rdy_t),
        .in_first(in_first), .in_last(in_last), .dataa(dataa), .datab(datab),
        .out_valid(ov_t), .out_ready(out_ready), .result(res_t), .out_sat(sat_t)
    );

    texture_mapper_legup_mac_pipelined #(
        .widthp(8), .signed_a(1'b1), .signed_b(1'b1), .out_shift(8)
    ) u_sh8 (
        .clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_ready(rdy_h),
        .in_first(in_first), .in_last(in_last), .dataa(dataa), .datab(datab),
        .out_valid(ov_h), .out_ready(out_ready), .result(res_h), .out_sat(sat_h)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_beat(input logic v, input logic [15:0] a, input logic [15:0] b,
                            input logic f, input logic l);
        in_valid = v;
        dataa    = a;
        datab    = b;
        in_first = f;
        in_last  = l;
    endtask

    task automatic do_reset();
        aclr      = 1'b1;
        clken     = 1'b1;
        out_ready = 1'b1;
        set_beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        cyc();
        cyc();
        aclr = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ov_u !== 1'b0 || res_u !== 32'd0 || sat_u !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b r=%h s=%b, need 0/0/0", ov_u, res_u, sat_u);
        end
        #1;
        checks++;
        if (rdy_u !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, need 1", rdy_u);
        end
        clken = 1'b0;
        #1;
        checks++;
        if (rdy_u !== 1'b0) begin
            errors++;
            $display("FAIL clken_ready: got %b, need 0", rdy_u);
        end
        clken = 1'b1;
        aclr  = 1'b1;
        #1;
        checks++;
        if (rdy_u !== 1'b0) begin
            errors++;
            $display("FAIL aclr_ready: got %b, need 0", rdy_u);
        end
        aclr = 1'b0;
        cyc();
    endtask

    task automatic test_uns_latency();
        do_reset();
        set_beat(1'b1, 16'd3, 16'd5, 1'b0, 1'b0);
        #1;
        checks++;
        if (rdy_u !== 1'b1) begin
            errors++;
            $display("FAIL lat_ready: got %b, need 1", rdy_u);
        end
        for (int k = 1; k <= 6; k++) begin
            cyc();
            set_beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
            checks++;
            if (ov_u !== (k == 4)) begin
                errors++;
                $display("FAIL lat_valid cyc %0d: got %b, need %b", k, ov_u, (k == 4));
            end
            if (k == 4) begin
                checks++;
                if (res_u !== 32'd15 || sat_u !== 1'b0) begin
                    errors++;
                    $display("FAIL lat_result: got %0d sat %b, need 15 sat 0", res_u, sat_u);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_beat(1'b1, 16'd1, 16'd2, 1'b0, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            cyc();
            if (k < 8) set_beat(1'b1, 16'(k + 1), 16'd2, 1'b0, 1'b0);
            else       set_beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
            checks++;
            if (ov_u !== (k >= 4 && k <= 11)) begin
                errors++;
                $display("FAIL b2b_valid cyc %0d: got %b, need %b", k, ov_u, (k >= 4 && k <= 11));
            end
            if (k >= 4 && k <= 11) begin
                checks++;
                if (res_u !== 32'(2 * (k - 3))) begin
                    errors++;
                    $display("FAIL b2b_result cyc %0d: got %0d, need %0d", k, res_u, 2 * (k - 3));
                end
            end
        end
    endtask

    task automatic test_signed();
        do_reset();
        set_beat(1'b1, 16'hFFF9, 16'd6, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k == 1) set_beat(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0);
            else        set_beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
            if (k == 4) begin
                checks++;
                if (ov_s !== 1'b1 || res_s !== 32'hFFFF_FFD6 || sat_s !== 1'b0) begin
                    errors++;
                    $display("FAIL signed_neg: got v=%b %h s=%b, need 1 ffffffd6 0",
                             ov_s, res_s, sat_s);
                end
            end
            if (k == 5) begin
                checks++;
                if (ov_s !== 1'b1 || res_s !== 32'h4000_0000 || sat_s !== 1'b0) begin
                    errors++;
                    $display("FAIL signed_min: got v=%b %h s=%b, need 1 40000000 0",
                             ov_s, res_s, sat_s);
                end
            end
        end
    endtask

    task automatic test_accumulate();
        logic [15:0] av [5];
        logic        fv [5];
        logic        lv [5];
        av = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        fv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        lv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        set_beat(1'b1, av[0], av[0], fv[0], lv[0]);
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k < 5) set_beat(1'b1, av[k], av[k], fv[k], lv[k]);
            else       set_beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
            checks++;
            if (ov_a !== (k == 7 || k == 8)) begin
                errors++;
                $display("FAIL acc_valid cyc %0d: got %b, need %b", k, ov_a, (k == 7 || k == 8));
            end
            if (k == 7) begin
                checks++;
                if (res_a !== 32'd30 || sat_a !== 1'b0) begin
                    errors++;
                    $display("FAIL acc_frame: got %0d sat %b, need 30 sat 0", res_a, sat_a);
                end
            end
            if (k == 8) begin
                checks++;
                if (res_a !== 32'd25) begin
                    errors++;
                    $display("FAIL acc_oneshot: got %0d, need 25", res_a);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        // No fresh reset: outputs still hold the previous test's results.
        set_beat(1'b1, 16'd1, 16'd1, 1'b1, 1'b0);
        cyc();
        set_beat(1'b1, 16'd2, 16'd2, 1'b0, 1'b0);
        cyc();
        set_beat(1'b1, 16'd3, 16'd3, 1'b0, 1'b0);
        cyc();
        set_beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        aclr = 1'b1;
        #1;
        checks++;
        if (rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready: got %b, need 0", rdy_a);
        end
        cyc();
        aclr = 1'b0;
        checks++;
        if (ov_a !== 1'b0 || res_a !== 32'd0 || sat_a !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_acc_clear: got v=%b r=%h s=%b, need 0/0/0", ov_a, res_a, sat_a);
        end
        checks++;
        if (ov_u !== 1'b0 || res_u !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_uns_clear: got v=%b r=%h, need 0/0", ov_u, res_u);
        end
        set_beat(1'b1, 16'd2, 16'd3, 1'b1, 1'b1);
        for (int k = 5; k <= 10; k++) begin
            cyc();
            set_beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
            checks++;
            if (ov_a !== (k == 8) || ov_u !== (k == 8)) begin
                errors++;
                $display("FAIL rstmid_valid cyc %0d: got acc=%b uns=%b, need %b",
                         k, ov_a, ov_u, (k == 8));
            end
            if (k == 8) begin
                checks++;
                if (res_a !== 32'd6 || res_u !== 32'd6) begin
                    errors++;
                    $display("FAIL rstmid_result: got acc=%0d uns=%0d, need 6", res_a, res_u);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int nxt = 0;
        int rcv = 0;
        do_reset();
        for (int c = 0; c < 60 && rcv < 10; c++) begin
            if (c > 0) cyc();
            out_ready = !(c >= 6 && c <= 10);
            if (nxt < 10) set_beat(1'b1, 16'(nxt + 1), 16'd3, 1'b0, 1'b0);
            else          set_beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
            #1;
            checks++;
            if (rdy_u !== !(c >= 6 && c <= 10)) begin
                errors++;
                $display("FAIL bp_ready cyc %0d: got %b, need %b", c, rdy_u, !(c >= 6 && c <= 10));
            end
            if (c >= 6 && c <= 10) begin
                checks++;
                if (ov_u !== 1'b1 || res_u !== 32'(3 * (rcv + 1))) begin
                    errors++;
                    $display("FAIL bp_hold cyc %0d: got v=%b %0d, need 1 %0d",
                             c, ov_u, res_u, 3 * (rcv + 1));
                end
            end
            if (ov_u && out_ready) begin
                checks++;
                if (res_u !== 32'(3 * (rcv + 1))) begin
                    errors++;
                    $display("FAIL bp_order item %0d: got %0d, need %0d", rcv, res_u, 3 * (rcv + 1));
                end
                rcv++;
            end
            if (in_valid && rdy_u) nxt++;
        end
        checks++;
        if (rcv != 10) begin
            errors++;
            $display("FAIL bp_count: got %0d results, need 10", rcv);
        end
        set_beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        set_beat(1'b1, 16'd100, 16'd100, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k == 1) set_beat(1'b1, 16'hFF9C, 16'd100, 1'b0, 1'b0);
            else        set_beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
            if (k == 4) begin
                checks++;
                if (ov_t !== 1'b1 || res_t !== 8'h7F || sat_t !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_pos: got v=%b %h s=%b, need 1 7f 1", ov_t, res_t, sat_t);
                end
                checks++;
                if (ov_h !== 1'b1 || res_h !== 8'd39 || sat_h !== 1'b0) begin
                    errors++;
                    $display("FAIL shift_pos: got v=%b %0d s=%b, need 1 39 0", ov_h, res_h, sat_h);
                end
            end
            if (k == 5) begin
                checks++;
                if (res_t !== 8'h80 || sat_t !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_neg: got %h s=%b, need 80 1", res_t, sat_t);
                end
                checks++;
                if (res_h !== 8'hD8 || sat_h !== 1'b0) begin
                    errors++;
                    $display("FAIL shift_neg: got %h s=%b, need d8 0", res_h, sat_h);
                end
            end
        end
    endtask

    initial begin
        aclr      = 1'b1;
        clken     = 1'b1;
        out_ready = 1'b1;
        set_beat(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        test_reset();
        test_uns_latency();
        test_back_to_back();
        test_signed();
        test_accumulate();
        test_reset_mid();
        test_backpressure();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
